wav_loader: RTL and testbench
=============================

WAV_LOADER -- requirements
Module: wav_loader

Interface
REQ-001 Parameter ADDR_W, default 17, sets the sample ROM address width in bits, which bounds capacity to 2^ADDR_W bytes.
REQ-002 Parameter INDEX, default 8'd0, is the ioctl_index value this block accepts; it ignores any other index.
REQ-003 clk_sys  in  1  sole clock, all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  high while the HPS download is in progress.
REQ-006 ioctl_index  in  8  download file index.
REQ-007 ioctl_wr  in  1  one-cycle strobe marking a valid byte.
REQ-008 ioctl_addr  in  25  byte offset within the file; strictly sequential from 0.
REQ-009 ioctl_dout  in  8  file byte.
REQ-010 rom_we  out  1  one-cycle write strobe to the sample ROM.
REQ-011 rom_addr  out  ADDR_W  sample ROM write address.
REQ-012 rom_data  out  8  sample ROM write data.
REQ-013 wav_len  out  ADDR_W+1  count of sample bytes written.
REQ-014 wav_rate  out  32  sample rate from the fmt chunk, in Hz.
REQ-015 wav_chans  out  16  channel count from the fmt chunk.
REQ-016 wav_bits  out  16  bits per sample from the fmt chunk.
REQ-017 wav_valid  out  1  high when the file parsed successfully.
REQ-018 wav_error  out  1  high when the file was rejected.
REQ-019 wav_trunc  out  1  high when the data chunk exceeded ROM capacity.

Function
REQ-020 The block shall process a byte only when ioctl_wr=1, ioctl_download=1 and ioctl_index=INDEX.
REQ-021 The rising edge of the accepted download (ioctl_download 0->1 with a matching index) shall clear wav_valid, wav_error, wav_trunc and wav_len, and enter state RIFF.
REQ-022 The states shall be IDLE, RIFF, RSIZE, WAVE, CID, CSIZE, FMT, SKIP, DATA, DONE, ERR.
REQ-023 RIFF: bytes 0-3 shall equal "RIFF"; a mismatch shall go to ERR.
REQ-024 RSIZE: bytes 4-7 shall be discarded.
REQ-025 WAVE: bytes 8-11 shall equal "WAVE"; a mismatch shall go to ERR.
REQ-026 CID: the block shall collect a 4-byte chunk ID, then go to CSIZE.
REQ-027 CSIZE: the block shall collect a 4-byte little-endian size, then dispatch to FMT for "fmt ", DATA for "data", or SKIP for any other ID.
REQ-028 A chunk with size 0 shall go straight back to CID without entering its body state.
REQ-029 FMT body: offset 0-1 audio_format shall be 1, else ERR; offset 2-3 shall load wav_chans; offset 4-7 shall load wav_rate; offset 14-15 shall load wav_bits; all other body bytes shall be discarded.
REQ-030 FMT end: wav_bits not in {8,16} shall go to ERR.
REQ-031 FMT end: a fmt chunk shorter than 16 bytes shall go to ERR.
REQ-032 SKIP and FMT shall consume exactly size bytes plus one pad byte when size is odd, then return to CID.
REQ-033 DATA: each byte shall produce rom_we=1 on the cycle after its ioctl_wr, with rom_data equal to the byte and rom_addr equal to wav_len, and wav_len shall then increment.
REQ-034 DATA: once wav_len reaches 2^ADDR_W, further bytes shall be dropped with no rom_we and wav_trunc shall be set.
REQ-035 DATA: after size bytes the block shall go to DONE and ignore the rest of the file.
REQ-036 A "data" chunk seen before any fmt chunk shall go to ERR.
REQ-037 ioctl_download falling while in DONE or DATA, with fmt captured, shall set wav_valid=1; a short data chunk shall keep its partial wav_len.
REQ-038 ioctl_download falling in any other non-IDLE state shall set wav_error=1.
REQ-039 Either falling-edge case shall return the block to IDLE.
REQ-040 ERR shall set wav_error=1 at once and ignore all bytes until the next download.
REQ-041 wav_valid and wav_error shall never be 1 together.
REQ-042 All multi-byte fields shall be assembled little-endian.

Reset
REQ-043 Reset shall take the block to IDLE with every output 0: rom_we, rom_addr, rom_data, wav_len, wav_rate, wav_chans, wav_bits, wav_valid, wav_error, wav_trunc.
REQ-044 Reset asserted mid-download shall abort the parse; bytes arriving after reset deasserts shall be ignored until a new download rising edge.

Verification
REQ-045 Stream a 44-byte header (mono, 8000 Hz, 8-bit, data size 4) plus bytes 11,22,33,44 -> four rom_we pulses at addresses 0-3 with those bytes; after download falls, wav_len=4, wav_rate=8000, wav_chans=1, wav_bits=8, wav_valid=1.
REQ-046 Insert a "LIST" chunk of size 5 before "data" -> 6 bytes skipped (including pad), data written from address 0, wav_valid=1.
REQ-047 Stream "RIFX" as the first 4 bytes -> wav_error=1 after byte 3, no rom_we, and wav_error remains 1 after download falls.
REQ-048 Set ADDR_W=4 and data size 20 -> exactly 16 rom_we pulses, wav_len=16, wav_trunc=1, wav_valid=1.
REQ-049 Assert reset after the 2nd data byte -> all outputs 0; the remaining bytes of that download produce no rom_we.
REQ-050 Run a download with ioctl_index=1 while INDEX=0 -> no rom_we and no change to any output.

Source files
------------

// File: rtl/wav_loader.sv
// wav_loader: parses a RIFF/WAVE file streamed over the HPS ioctl download
// port, captures the fmt chunk fields and writes the data chunk bytes into
// a sample ROM.
//
// Ports
//   clk_sys         sole clock, everything on its rising edge
//   reset           synchronous, active-high
//   ioctl_download  high while a download is in progress
//   ioctl_index     file index, only INDEX is accepted
//   ioctl_wr        one-cycle strobe qualifying ioctl_dout
//   ioctl_addr      byte offset within the file (sequential from 0)
//   ioctl_dout      file byte
//   rom_we/addr/data  sample ROM write port (one strobe per data byte)
//   wav_len         number of sample bytes written
//   wav_rate/chans/bits  fmt chunk fields
//   wav_valid/error/trunc  parse status
module wav_loader #(
    parameter int         ADDR_W = 17,
    parameter logic [7:0] INDEX  = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic [ADDR_W:0]   wav_len,
    output logic [31:0]       wav_rate,
    output logic [15:0]       wav_chans,
    output logic [15:0]       wav_bits,
    output logic              wav_valid,
    output logic              wav_error,
    output logic              wav_trunc
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RIFF  = 4'd1;
    localparam logic [3:0] S_RSIZE = 4'd2;
    localparam logic [3:0] S_WAVE  = 4'd3;
    localparam logic [3:0] S_CID   = 4'd4;
    localparam logic [3:0] S_CSIZE = 4'd5;
    localparam logic [3:0] S_FMT   = 4'd6;
    localparam logic [3:0] S_SKIP  = 4'd7;
    localparam logic [3:0] S_DATA  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;
    localparam logic [3:0] S_ERR   = 4'd10;

    localparam logic [31:0] TAG_RIFF = "RIFF";
    localparam logic [31:0] TAG_WAVE = "WAVE";
    localparam logic [31:0] TAG_FMT  = "fmt ";
    localparam logic [31:0] TAG_DATA = "data";

    // Tags are stored first-character-in-MSB, so file byte k is byte 3-k.
    function automatic logic [7:0] tag_byte(input logic [31:0] tag, input logic [1:0] idx);
        logic [7:0] ch;
        case (idx)
            2'd0:    ch = tag[31:24];
            2'd1:    ch = tag[23:16];
            2'd2:    ch = tag[15:8];
            default: ch = tag[7:0];
        endcase
        return ch;
    endfunction

    logic [3:0]        state_reg;
    logic              dl_prev_reg;
    logic [1:0]        cnt_reg;
    logic [31:0]       cid_reg;
    logic [31:0]       size_reg;
    logic [31:0]       csize_reg;
    logic [32:0]       off_reg;
    logic              fmt_seen_reg;
    logic              rom_we_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [7:0]        rom_data_reg;
    logic [ADDR_W:0]   len_reg;
    logic [31:0]       rate_reg;
    logic [15:0]       chans_reg;
    logic [15:0]       bits_reg;
    logic              valid_reg;
    logic              error_reg;
    logic              trunc_reg;

    logic        idx_match;
    logic        dl_rise;
    logic        dl_fall;
    logic        byte_ok;
    logic [31:0] size_full;
    logic [32:0] off_next;
    logic        body_end;
    logic        data_end;
    logic [15:0] bits_new;
    logic        fmt_bad_format;
    logic        fmt_end_ok;

    always_comb begin
        idx_match = (ioctl_index == INDEX);
        dl_rise   = ioctl_download && !dl_prev_reg && idx_match;
        dl_fall   = !ioctl_download && dl_prev_reg;
        byte_ok   = ioctl_wr && ioctl_download && idx_match;
        // Size arrives LSB first; shifting in at the top leaves it aligned
        // after the fourth byte.
        size_full = {ioctl_dout, size_reg[31:8]};
        off_next  = off_reg + 33'd1;
        // Chunk bodies are word aligned: odd sizes carry one pad byte.
        body_end  = (off_next == ({1'b0, csize_reg} + {32'd0, csize_reg[0]}));
        data_end  = (off_next == {1'b0, csize_reg});
        bits_new  = bits_reg;
        if (off_reg == 33'd14) bits_new = {bits_reg[15:8], ioctl_dout};
        if (off_reg == 33'd15) bits_new = {ioctl_dout, bits_reg[7:0]};
        // audio_format must be exactly 16'h0001 (PCM).
        fmt_bad_format = ((off_reg == 33'd0) && (ioctl_dout != 8'd1)) ||
                         ((off_reg == 33'd1) && (ioctl_dout != 8'd0));
        fmt_end_ok = (csize_reg >= 32'd16) && ((bits_new == 16'd8) || (bits_new == 16'd16));
    end

    always_ff @(posedge clk_sys) begin
        rom_we_reg  <= 1'b0;
        // Sampled even during reset so a download held high across reset
        // is not mistaken for a new rising edge.
        dl_prev_reg <= ioctl_download;
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 2'd0;
            cid_reg      <= 32'd0;
            size_reg     <= 32'd0;
            csize_reg    <= 32'd0;
            off_reg      <= 33'd0;
            fmt_seen_reg <= 1'b0;
            rom_addr_reg <= '0;
            rom_data_reg <= 8'd0;
            len_reg      <= '0;
            rate_reg     <= 32'd0;
            chans_reg    <= 16'd0;
            bits_reg     <= 16'd0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            trunc_reg    <= 1'b0;
        end else if (dl_rise) begin
            state_reg    <= S_RIFF;
            cnt_reg      <= 2'd0;
            fmt_seen_reg <= 1'b0;
            len_reg      <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
            trunc_reg    <= 1'b0;
        end else if (dl_fall && (state_reg != S_IDLE)) begin
            if (((state_reg == S_DONE) || (state_reg == S_DATA)) && fmt_seen_reg)
                valid_reg <= 1'b1;
            else
                error_reg <= 1'b1;
            state_reg <= S_IDLE;
        end else if (byte_ok) begin
            case (state_reg)
                S_RIFF, S_WAVE: begin
                    if (ioctl_dout != tag_byte((state_reg == S_RIFF) ? TAG_RIFF : TAG_WAVE,
                                               ioctl_addr[1:0])) begin
                        state_reg <= S_ERR;
                        error_reg <= 1'b1;
                    end else if (ioctl_addr == 25'd3) begin
                        state_reg <= S_RSIZE;
                    end else if (ioctl_addr == 25'd11) begin
                        state_reg <= S_CID;
                    end
                end
                S_RSIZE: begin
                    if (ioctl_addr == 25'd7) state_reg <= S_WAVE;
                end
                S_CID: begin
                    cid_reg <= {cid_reg[23:0], ioctl_dout};
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) state_reg <= S_CSIZE;
                end
                S_CSIZE: begin
                    size_reg <= size_full;
                    cnt_reg  <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        csize_reg <= size_full;
                        off_reg   <= 33'd0;
                        if ((cid_reg == TAG_DATA) && !fmt_seen_reg) begin
                            state_reg <= S_ERR;
                            error_reg <= 1'b1;
                        end else if (size_full == 32'd0) begin
                            state_reg <= S_CID;
                        end else if (cid_reg == TAG_DATA) begin
                            state_reg <= S_DATA;
                        end else if (cid_reg == TAG_FMT) begin
                            state_reg <= S_FMT;
                        end else begin
                            state_reg <= S_SKIP;
                        end
                    end
                end
                S_FMT: begin
                    off_reg <= off_next;
                    case (off_reg)
                        33'd2:   chans_reg[7:0]   <= ioctl_dout;
                        33'd3:   chans_reg[15:8]  <= ioctl_dout;
                        33'd4:   rate_reg[7:0]    <= ioctl_dout;
                        33'd5:   rate_reg[15:8]   <= ioctl_dout;
                        33'd6:   rate_reg[23:16]  <= ioctl_dout;
                        33'd7:   rate_reg[31:24]  <= ioctl_dout;
                        33'd14,
                        33'd15:  bits_reg         <= bits_new;
                        default: ;
                    endcase
                    if (fmt_bad_format) begin
                        state_reg <= S_ERR;
                        error_reg <= 1'b1;
                    end else if (body_end) begin
                        if (fmt_end_ok) begin
                            fmt_seen_reg <= 1'b1;
                            state_reg    <= S_CID;
                        end else begin
                            state_reg <= S_ERR;
                            error_reg <= 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    off_reg <= off_next;
                    if (body_end) state_reg <= S_CID;
                end
                S_DATA: begin
                    off_reg <= off_next;
                    // The top bit of len_reg set means the ROM is full.
                    if (!len_reg[ADDR_W]) begin
                        rom_we_reg   <= 1'b1;
                        rom_addr_reg <= len_reg[ADDR_W-1:0];
                        rom_data_reg <= ioctl_dout;
                        len_reg      <= len_reg + 1'b1;
                    end else begin
                        trunc_reg <= 1'b1;
                    end
                    if (data_end) state_reg <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign rom_we    = rom_we_reg;
    assign rom_addr  = rom_addr_reg;
    assign rom_data  = rom_data_reg;
    assign wav_len   = len_reg;
    assign wav_rate  = rate_reg;
    assign wav_chans = chans_reg;
    assign wav_bits  = bits_reg;
    assign wav_valid = valid_reg;
    assign wav_error = error_reg;
    assign wav_trunc = trunc_reg;

endmodule

// File: tb/tb_wav_loader.sv
// tb_wav_loader: directed bench for wav_loader. Two instances share the
// ioctl bus: dut (default ADDR_W=17) and dut4 (ADDR_W=4) for the
// truncation case.
module tb_wav_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;

    logic        a_rom_we;
    logic [16:0] a_rom_addr;
    logic [7:0]  a_rom_data;
    logic [17:0] a_wav_len;
    logic [31:0] a_wav_rate;
    logic [15:0] a_wav_chans;
    logic [15:0] a_wav_bits;
    logic        a_wav_valid;
    logic        a_wav_error;
    logic        a_wav_trunc;

    logic        b_rom_we;
    logic [3:0]  b_rom_addr;
    logic [7:0]  b_rom_data;
    logic [4:0]  b_wav_len;
    logic [31:0] b_wav_rate;
    logic [15:0] b_wav_chans;
    logic [15:0] b_wav_bits;
    logic        b_wav_valid;
    logic        b_wav_error;
    logic        b_wav_trunc;

    wav_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .rom_we(a_rom_we), .rom_addr(a_rom_addr),
        .rom_data(a_rom_data), .wav_len(a_wav_len), .wav_rate(a_wav_rate),
        .wav_chans(a_wav_chans), .wav_bits(a_wav_bits), .wav_valid(a_wav_valid),
        .wav_error(a_wav_error), .wav_trunc(a_wav_trunc)
    );

    wav_loader #(.ADDR_W(4)) dut4 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .rom_we(b_rom_we), .rom_addr(b_rom_addr),
        .rom_data(b_rom_data), .wav_len(b_wav_len), .wav_rate(b_wav_rate),
        .wav_chans(b_wav_chans), .wav_bits(b_wav_bits), .wav_valid(b_wav_valid),
        .wav_error(b_wav_error), .wav_trunc(b_wav_trunc)
    );

    always #5 clk_sys = ~clk_sys;

    // ROM write logs
    int          we_cnt = 0;
    logic [16:0] we_addr [256];
    logic [7:0]  we_data [256];
    int          we4_cnt = 0;
    logic [3:0]  we4_last_addr = 4'd0;
    logic [7:0]  we4_last_data = 8'd0;

    always @(posedge clk_sys) begin
        if (a_rom_we) begin
            if (we_cnt < 256) begin
                we_addr[we_cnt] = a_rom_addr;
                we_data[we_cnt] = a_rom_data;
            end
            we_cnt = we_cnt + 1;
            $display("[%0t] dut  rom_we addr=%0d data=%0d", $time, a_rom_addr, a_rom_data);
        end
        if (b_rom_we) begin
            we4_last_addr = b_rom_addr;
            we4_last_data = b_rom_data;
            we4_cnt = we4_cnt + 1;
            $display("[%0t] dut4 rom_we addr=%0d data=%0d", $time, b_rom_addr, b_rom_data);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [7:0] q[$];

    task automatic push_tag(input logic [31:0] t);
        q.push_back(t[31:24]);
        q.push_back(t[23:16]);
        q.push_back(t[15:8]);
        q.push_back(t[7:0]);
    endtask

    task automatic push32(input logic [31:0] v);
        q.push_back(v[7:0]);
        q.push_back(v[15:8]);
        q.push_back(v[23:16]);
        q.push_back(v[31:24]);
    endtask

    task automatic push16(input logic [15:0] v);
        q.push_back(v[7:0]);
        q.push_back(v[15:8]);
    endtask

    task automatic build_hdr(input logic [15:0] ch, input logic [31:0] rate,
                             input logic [15:0] bits, input logic [31:0] dlen,
                             input bit with_list);
        logic [31:0] blk;
        blk = {16'd0, ch} * {16'd0, bits} / 32'd8;
        q.delete();
        push_tag("RIFF");
        push32(32'd36 + dlen + (with_list ? 32'd14 : 32'd0));
        push_tag("WAVE");
        push_tag("fmt ");
        push32(32'd16);
        push16(16'd1);
        push16(ch);
        push32(rate);
        push32(rate * blk);
        push16(blk[15:0]);
        push16(bits);
        if (with_list) begin
            push_tag("LIST");
            push32(32'd5);
            for (int i = 0; i < 5; i++) q.push_back(8'h55);
            q.push_back(8'h00);
        end
        push_tag("data");
        push32(dlen);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b0;
        ioctl_addr = ioctl_addr + 25'd1;
        @(posedge clk_sys); #1;
    endtask

    task automatic send_q(input int from);
        for (int i = from; i < q.size(); i++) send_byte(q[i]);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_addr     = 25'd0;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    int base;
    int base4;

    initial begin
        // Reset
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(posedge clk_sys); #1;
        $display("step: reset");
        check("rst_rom_we", a_rom_we, 0);
        check("rst_rom_addr", a_rom_addr, 0);
        check("rst_rom_data", a_rom_data, 0);
        check("rst_len", a_wav_len, 0);
        check("rst_rate", a_wav_rate, 0);
        check("rst_chans", a_wav_chans, 0);
        check("rst_bits", a_wav_bits, 0);
        check("rst_valid", a_wav_valid, 0);
        check("rst_error", a_wav_error, 0);
        check("rst_trunc", a_wav_trunc, 0);

        // Basic mono 8 kHz 8-bit file with four samples
        $display("step: basic file");
        base = we_cnt;
        build_hdr(16'd1, 32'd8000, 16'd8, 32'd4, 1'b0);
        q.push_back(8'd11); q.push_back(8'd22); q.push_back(8'd33); q.push_back(8'd44);
        start_dl(8'd0);
        send_q(0);
        check("t1_valid_before_fall", a_wav_valid, 0);
        end_dl();
        check("t1_we_count", we_cnt - base, 4);
        check("t1_addr0", we_addr[base], 0);
        check("t1_data0", we_data[base], 11);
        check("t1_addr1", we_addr[base+1], 1);
        check("t1_data1", we_data[base+1], 22);
        check("t1_addr2", we_addr[base+2], 2);
        check("t1_data2", we_data[base+2], 33);
        check("t1_addr3", we_addr[base+3], 3);
        check("t1_data3", we_data[base+3], 44);
        check("t1_len", a_wav_len, 4);
        check("t1_rate", a_wav_rate, 8000);
        check("t1_chans", a_wav_chans, 1);
        check("t1_bits", a_wav_bits, 8);
        check("t1_valid", a_wav_valid, 1);
        check("t1_error", a_wav_error, 0);

        // LIST chunk of odd size ahead of data, stereo 44.1 kHz 16-bit
        $display("step: LIST chunk skip");
        base = we_cnt;
        build_hdr(16'd2, 32'd44100, 16'd16, 32'd3, 1'b1);
        q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
        start_dl(8'd0);
        send_q(0);
        end_dl();
        check("t2_we_count", we_cnt - base, 3);
        check("t2_addr0", we_addr[base], 0);
        check("t2_data0", we_data[base], 8'hA1);
        check("t2_data2", we_data[base+2], 8'hA3);
        check("t2_len", a_wav_len, 3);
        check("t2_rate", a_wav_rate, 44100);
        check("t2_chans", a_wav_chans, 2);
        check("t2_bits", a_wav_bits, 16);
        check("t2_valid", a_wav_valid, 1);

        // Foreign index: nothing may change
        $display("step: foreign index");
        base = we_cnt;
        build_hdr(16'd1, 32'd8000, 16'd8, 32'd2, 1'b0);
        q.push_back(8'd7); q.push_back(8'd8);
        start_dl(8'd1);
        send_q(0);
        end_dl();
        check("t6_we_count", we_cnt - base, 0);
        check("t6_len", a_wav_len, 3);
        check("t6_rate", a_wav_rate, 44100);
        check("t6_chans", a_wav_chans, 2);
        check("t6_bits", a_wav_bits, 16);
        check("t6_valid", a_wav_valid, 1);
        check("t6_error", a_wav_error, 0);

        // Bad RIFF tag
        $display("step: RIFX rejected");
        base = we_cnt;
        build_hdr(16'd1, 32'd8000, 16'd8, 32'd2, 1'b0);
        q.push_back(8'd5); q.push_back(8'd6);
        start_dl(8'd0);
        check("t3_valid_cleared", a_wav_valid, 0);
        send_byte("R");
        send_byte("I");
        send_byte("F");
        check("t3_error_before_x", a_wav_error, 0);
        send_byte("X");
        check("t3_error_after_x", a_wav_error, 1);
        check("t3_valid_after_x", a_wav_valid, 0);
        send_q(4);
        end_dl();
        check("t3_we_count", we_cnt - base, 0);
        check("t3_error_final", a_wav_error, 1);
        check("t3_valid_final", a_wav_valid, 0);

        // Data larger than a 16-byte ROM
        $display("step: truncation");
        base  = we_cnt;
        base4 = we4_cnt;
        build_hdr(16'd1, 32'd8000, 16'd8, 32'd20, 1'b0);
        for (int i = 1; i <= 20; i++) q.push_back(8'(i));
        start_dl(8'd0);
        send_q(0);
        end_dl();
        check("t4_we4_count", we4_cnt - base4, 16);
        check("t4_we4_last_addr", we4_last_addr, 15);
        check("t4_we4_last_data", we4_last_data, 16);
        check("t4_len4", b_wav_len, 16);
        check("t4_trunc4", b_wav_trunc, 1);
        check("t4_valid4", b_wav_valid, 1);
        check("t4_error4", b_wav_error, 0);
        check("t4_rate4", b_wav_rate, 8000);
        check("t4_chans4", b_wav_chans, 1);
        check("t4_bits4", b_wav_bits, 8);
        check("t4_we_count", we_cnt - base, 20);
        check("t4_len", a_wav_len, 20);
        check("t4_trunc", a_wav_trunc, 0);

        // Reset in the middle of the data chunk
        $display("step: reset mid-download");
        build_hdr(16'd2, 32'd22050, 16'd16, 32'd4, 1'b0);
        start_dl(8'd0);
        send_q(0);
        send_byte(8'd91);
        send_byte(8'd92);
        check("t5_len_pre_reset", a_wav_len, 2);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        check("t5_rom_we", a_rom_we, 0);
        check("t5_rom_addr", a_rom_addr, 0);
        check("t5_rom_data", a_rom_data, 0);
        check("t5_len", a_wav_len, 0);
        check("t5_rate", a_wav_rate, 0);
        check("t5_chans", a_wav_chans, 0);
        check("t5_bits", a_wav_bits, 0);
        check("t5_valid", a_wav_valid, 0);
        check("t5_error", a_wav_error, 0);
        check("t5_trunc", a_wav_trunc, 0);
        base = we_cnt;
        send_byte(8'd93);
        send_byte(8'd94);
        end_dl();
        check("t5_we_after_reset", we_cnt - base, 0);
        check("t5_len_final", a_wav_len, 0);
        check("t5_valid_final", a_wav_valid, 0);
        check("t5_error_final", a_wav_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
